alu_word_sequencer: RTL and testbench
=====================================

Name: alu_word_sequencer

Overview:
- Multi-cycle sequencer that runs one word-wide operation through the 4-bit parallel ALU, one nibble per clock, least-significant nibble first.
- Sits directly upstream of the ALU: drives its A, B, S, M and Pin inputs.
- Also consumes the ALU outputs: R is assembled into the word result, and carry P[3] is chained into the next nibble's Pin.
- Gives the central unit a word-wide ALU with a start/done handshake.

Parameters:
- NIBBLES, 4, number of 4-bit slices per word; word width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  system clock; rising edge active.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled on rising clk.
- op_s  input  4  ALU function select; latched at start.
- op_m  input  1  ALU mode; latched at start.
- cin  input  1  initial carry into nibble 0; latched at start.
- a_word  input  W  operand A; latched at start.
- b_word  input  W  operand B; latched at start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result, cout and zero are valid.
- result  output  W  assembled word result; holds until the next accepted start.
- cout  output  1  carry out of the top nibble, i.e. the last P[3] captured.
- zero  output  1  high when result == 0; valid with done and held after.
- alu_a  output  4  nibble of A to the ALU.
- alu_b  output  4  nibble of B to the ALU.
- alu_s  output  4  to ALU S.
- alu_m  output  1  to ALU M.
- alu_pin  output  1  to ALU Pin.
- alu_r  input  4  ALU result R (combinational).
- alu_p  input  4  ALU carry vector P; only alu_p[3] is used.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state = IDLE; busy = 0, done = 0, result = 0, cout = 0, zero = 0.
  - Nibble index = 0; all operand and opcode registers cleared.
  - No done pulse is generated for an aborted operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - start = 1 latches a_word, b_word, op_s, op_m and cin; index = 0; carry register = cin; go to RUN.
  - result, cout and zero are not cleared on start; they are overwritten during RUN.
- RUN (exactly NIBBLES cycles):
  - Combinational drive from registers:
    - alu_a = A_reg[4*idx+3:4*idx].
    - alu_b = B_reg[4*idx+3:4*idx].
    - alu_s = S_reg, alu_m = M_reg.
    - alu_pin = carry register.
  - On each rising edge:
    - result[4*idx+3:4*idx] <= alu_r.
    - carry <= alu_p[3].
    - idx <= idx+1.
  - On the edge with idx == NIBBLES-1: cout <= alu_p[3]; zero <= (final assembled result == 0); go to DONE.
- DONE (one cycle): done = 1, busy = 0; next state is IDLE, or RUN if start = 1 (back-to-back accept).
- busy = 1 exactly in RUN.
- Latency: start accepted at edge k → done high in the cycle after edge k+NIBBLES. Throughput is one operation per NIBBLES+1 cycles.
- start while busy: ignored; no queuing, and operand inputs may change freely.
- Logic mode (M = 1): carry is still chained and cout reports the ALU's P[3] unmodified. The sequencer never inverts or interprets carry polarity; Pin/P pass through raw.
- In IDLE and DONE, alu_* outputs hold their last driven values; the sequencer ignores the ALU response.
- NIBBLES = 1: RUN lasts one cycle and behaves identically otherwise.
- Index counter width = clog2(NIBBLES) with a minimum of 1; no wrap beyond NIBBLES-1.

Test Plan:
All tests use a bench ALU model in add mode: R = a + b + Pin (low 4 bits), P[3] = carry out.
1. NIBBLES=4, a=0x1234, b=0x4321, cin=0, start at cycle 0:
   - alu_a sequence 4,3,2,1; busy high for cycles 1–4; done at cycle 5.
   - result=0x5555, cout=0, zero=0.
2. Full carry ripple: a=0xFFFF, b=0x0000, cin=1:
   - alu_pin per nibble = 1,1,1,1.
   - result=0x0000, cout=1, zero=1.
3. start pulsed at cycles 2 and 3 while busy:
   - Ignored; exactly one done; result unchanged by the second operand set.
4. start held high through DONE:
   - Second operation begins the cycle after done; second done arrives 5 cycles after the first.
   - Results of both operations are correct.
5. rst asserted asynchronously mid-RUN (idx = 2):
   - Immediately busy=0, done=0, result=0, cout=0, zero=0.
   - No done pulse follows; a new start after reset release works normally.
6. Logic mode: op_m=1, bench model R = a XOR b with P = 0, a=0xA5A5, b=0xFFFF:
   - alu_m=1 and alu_s=op_s on every RUN cycle.
   - result=0x5A5A, cout=0.

Source files
------------

// File: rtl/alu_word_sequencer.sv
// Word-wide front end for a 4-bit parallel ALU: runs one operation nibble by nibble,
// LSB first, chaining P[3] into the next Pin, with a start/done handshake.
`timescale 1ns/1ps
module alu_word_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             op_s,
  input  logic                   op_m,
  input  logic                   cin,
  input  logic [4*NIBBLES-1:0]   a_word,
  input  logic [4*NIBBLES-1:0]   b_word,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   zero,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [3:0]             alu_s,
  output logic                   alu_m,
  output logic                   alu_pin,
  input  logic [3:0]             alu_r,
  input  logic [3:0]             alu_p
);
  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one nibble per clock through the ALU
  // DONE  | one-cycle done pulse; start here is accepted back-to-back

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic            accept, last;
  logic [W-1:0]    a_reg, b_reg, result_nxt;
  logic [3:0]      s_reg;
  logic            m_reg, carry;
  logic [IW-1:0]   idx;
  logic            unused_p;

  assign unused_p = ^alu_p[2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = (idx == LAST);
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    result_nxt             = result;
    result_nxt[4*idx +: 4] = alu_r;
  end

  // idx and carry stay put on the final nibble so the ALU inputs hold
  // their last driven values through DONE and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      s_reg  <= '0;
      m_reg  <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
    end else if (accept) begin
      a_reg <= a_word;
      b_reg <= b_word;
      s_reg <= op_s;
      m_reg <= op_m;
      carry <= cin;
      idx   <= '0;
    end else if (state == RUN) begin
      result <= result_nxt;
      if (last) begin
        cout <= alu_p[3];
        zero <= (result_nxt == '0);
      end else begin
        carry <= alu_p[3];
        idx   <= idx + 1'b1;
      end
    end
  end

  assign alu_a   = a_reg[4*idx +: 4];
  assign alu_b   = b_reg[4*idx +: 4];
  assign alu_s   = s_reg;
  assign alu_m   = m_reg;
  assign alu_pin = carry;

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Scoreboard bench for alu_word_sequencer with a behavioural 4-bit ALU attached;
// expected words come from whole-word arithmetic, not nibble stepping.
`timescale 1ns/1ps
module tb_alu_word_sequencer;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op_s = '0;
  logic         op_m = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a_word = '0, b_word = '0;
  logic         busy, done, cout, zero;
  logic [W-1:0] result;
  logic [3:0]   alu_a, alu_b, alu_s, alu_r, alu_p;
  logic         alu_m, alu_pin;
  logic [4:0]   sum4;

  alu_word_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op_s(op_s), .op_m(op_m), .cin(cin),
    .a_word(a_word), .b_word(b_word), .busy(busy), .done(done), .result(result),
    .cout(cout), .zero(zero), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_m(alu_m), .alu_pin(alu_pin), .alu_r(alu_r), .alu_p(alu_p)
  );

  always #5 clk = ~clk;

  // Bench ALU: add in arithmetic mode, XOR with P=0 in logic mode.
  assign sum4  = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_pin};
  assign alu_r = alu_m ? (alu_a ^ alu_b) : sum4[3:0];
  assign alu_p = alu_m ? 4'b0 : {sum4[4], 3'b0};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  logic [W+1:0] q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, b, input logic c, m);
    logic [W:0] s;
    if (m) s = {1'b0, a ^ b};
    else   s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    return {s[W-1:0], s[W], s[W-1:0] == '0};
  endfunction

  task automatic start_op(input logic [W-1:0] a, b, input logic c, m, input logic [3:0] s);
    a_word = a; b_word = b; cin = c; op_m = m; op_s = s; start = 1'b1;
    q.push_back(ref_op(a, b, c, m));
    @(posedge clk); #1;
    start  = 1'b0;
    a_word = W'($urandom); b_word = W'($urandom);
    cin    = 1'($urandom); op_m = 1'($urandom); op_s = 4'($urandom);
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        t = cyc;
        break;
      end
    end
    chk("done_seen", t >= 0, 1);
  endtask

  initial begin
    int t1, t2, nd, gap;
    logic [W-1:0] ra, rb;
    logic [W+1:0] e;

    fork
      forever begin
        @(negedge clk);
        if (!rst && done) begin
          if (q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_done: got done=1 required no pending op (t=%0t)", $time);
          end else begin
            e = q.pop_front();
            chk("result", result, e[W+1:2]);
            chk("cout", cout, e[1]);
            chk("zero", zero, e[0]);
          end
        end
      end
    join_none

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout_zero", {cout, zero}, 0);
    rst = 1'b0;

    // 1: basic add, nibble sequence and latency
    @(posedge clk); #1;
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0, 4'h9);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("t1_alu_a", alu_a, 4 - i);
      chk("t1_busy", busy, 1);
      chk("t1_done_low", done, 0);
    end
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_busy_low", busy, 0);
    chk("t1_result", result, 16'h5555);

    // 2: full carry ripple
    @(posedge clk); #1;
    start_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 4'h9);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("t2_pin", alu_pin, 1);
    end
    wait_done(t1);
    chk("t2_res_cout_zero", {result, cout, zero}, {16'h0000, 2'b11});

    // 3: start pulses while busy are ignored
    @(posedge clk); #1;
    start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 4'h9);
    @(posedge clk); #1;
    start = 1'b1; a_word = 16'hDEAD; b_word = 16'hBEEF; cin = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(t1);
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("t3_extra_done", nd, 0);
    chk("t3_result", result, 16'h1010);

    // 4: start held through DONE
    @(posedge clk); #1;
    a_word = 16'h0123; b_word = 16'h1111; cin = 1'b0; op_m = 1'b0; start = 1'b1;
    q.push_back(ref_op(16'h0123, 16'h1111, 1'b0, 1'b0));
    @(posedge clk); #1;
    a_word = 16'h8000; b_word = 16'h8001; cin = 1'b1;
    q.push_back(ref_op(16'h8000, 16'h8001, 1'b1, 1'b0));
    wait_done(t1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(t2);
    chk("t4_spacing", t2 - t1, N + 1);

    // 5: asynchronous reset mid-RUN
    @(posedge clk); #1;
    start_op(16'h7777, 16'h1111, 1'b0, 1'b0, 4'h9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_result", result, 0);
    chk("t5_cout_zero", {cout, zero}, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("t5_no_done", nd, 0);
    @(posedge clk); #1;
    start_op(16'h2222, 16'h3333, 1'b1, 1'b0, 4'h9);
    wait_done(t1);

    // 6: logic mode
    @(posedge clk); #1;
    start_op(16'hA5A5, 16'hFFFF, 1'b0, 1'b1, 4'h6);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("t6_alu_m", alu_m, 1);
      chk("t6_alu_s", alu_s, 4'h6);
    end
    wait_done(t1);
    chk("t6_result", {result, cout}, {16'h5A5A, 1'b0});

    // randomized operations, with gaps, back-to-back starts and ignored starts
    repeat (60) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ~ra;
      start_op(ra, rb, 1'($urandom), 1'($urandom_range(0, 3) == 0), 4'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      wait_done(t1);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
